// File: rtl/prf_free_list.sv
// Physical-register free list: a free bitmap that grants up to two of the
// lowest free PRF indices per cycle, reclaims retired indices and rebuilds on mispredict.
module prf_free_list #(
  parameter  int PRF_SIZE = 64,
  parameter  int ARF_SIZE = 32,
  localparam int IDX_W    = $clog2(PRF_SIZE)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      RRAT_free_valid,
  input  logic [IDX_W-1:0]          RRAT_free_idx,
  input  logic                      mispredict_sig,
  input  logic [ARF_SIZE*IDX_W-1:0] mispredict_up_idx,
  input  logic [1:0]                alloc_req,
  output logic [1:0]                alloc_valid,
  output logic [IDX_W-1:0]          alloc_idx0,
  output logic [IDX_W-1:0]          alloc_idx1,
  output logic [IDX_W:0]            free_count,
  output logic                      empty,
  output logic                      double_free
);

  logic [PRF_SIZE-1:0] free_bm_q, free_bm_d;
  logic                double_free_q, double_free_d;

  logic [IDX_W-1:0]    low0, low1;
  logic                have0, have1;
  logic [IDX_W:0]      cnt;
  logic                gnt0, gnt1;
  logic                rel;
  logic [PRF_SIZE-1:0] used_bm;

  // Lowest and second-lowest free index; bit 0 is never free so the scan skips it.
  always_comb begin
    low0  = '0;
    low1  = '0;
    have0 = 1'b0;
    have1 = 1'b0;
    cnt   = '0;
    for (int i = 1; i < PRF_SIZE; i++) begin
      cnt = cnt + {{IDX_W{1'b0}}, free_bm_q[i]};
      if (free_bm_q[i]) begin
        if (!have0) begin
          low0  = IDX_W'(i);
          have0 = 1'b1;
        end else if (!have1) begin
          low1  = IDX_W'(i);
          have1 = 1'b1;
        end
      end
    end
  end

  assign alloc_idx0  = low0;
  assign alloc_idx1  = alloc_req[0] ? low1 : low0;
  assign alloc_valid = mispredict_sig ? 2'b00 : {have1, have0};
  assign free_count  = cnt;
  assign empty       = (cnt == '0);
  assign double_free = double_free_q;

  // Way1 needs the second entry only when way0 also takes one.
  assign gnt0 = alloc_req[0] && have0 && !mispredict_sig;
  assign gnt1 = alloc_req[1] && (alloc_req[0] ? have1 : have0) && !mispredict_sig;
  assign rel  = RRAT_free_valid && !mispredict_sig && (RRAT_free_idx != '0);

  always_comb begin
    used_bm = '0;
    for (int a = 0; a < ARF_SIZE; a++)
      used_bm[mispredict_up_idx[a*IDX_W +: IDX_W]] = 1'b1;
  end

  always_comb begin
    free_bm_d     = free_bm_q;
    double_free_d = 1'b0;
    if (mispredict_sig) begin
      free_bm_d = ~used_bm;
    end else begin
      if (gnt0) free_bm_d[alloc_idx0] = 1'b0;
      if (gnt1) free_bm_d[alloc_idx1] = 1'b0;
      // A release of an already-free index only flags the error; granting it still wins.
      if (rel) begin
        if (free_bm_q[RRAT_free_idx]) double_free_d = 1'b1;
        else                          free_bm_d[RRAT_free_idx] = 1'b1;
      end
    end
    free_bm_d[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      free_bm_q     <= {{(PRF_SIZE-1){1'b1}}, 1'b0};
      double_free_q <= 1'b0;
    end else begin
      free_bm_q     <= free_bm_d;
      double_free_q <= double_free_d;
    end
  end

endmodule

// File: tb/tb_prf_free_list.sv
// Bench for prf_free_list: directed vector table, drain/reset corner sequences,
// then random traffic against a sorted-free-list reference model.
module tb_prf_free_list;
  localparam int PRF_SIZE = 64;
  localparam int ARF_SIZE = 32;
  localparam int IDX_W    = 6;

  logic                      clock = 1'b0;
  logic                      reset;
  logic                      RRAT_free_valid;
  logic [IDX_W-1:0]          RRAT_free_idx;
  logic                      mispredict_sig;
  logic [ARF_SIZE*IDX_W-1:0] mispredict_up_idx;
  logic [1:0]                alloc_req;
  logic [1:0]                alloc_valid;
  logic [IDX_W-1:0]          alloc_idx0, alloc_idx1;
  logic [IDX_W:0]            free_count;
  logic                      empty, double_free;

  prf_free_list #(.PRF_SIZE(PRF_SIZE), .ARF_SIZE(ARF_SIZE)) dut (
    .clock(clock), .reset(reset),
    .RRAT_free_valid(RRAT_free_valid), .RRAT_free_idx(RRAT_free_idx),
    .mispredict_sig(mispredict_sig), .mispredict_up_idx(mispredict_up_idx),
    .alloc_req(alloc_req), .alloc_valid(alloc_valid),
    .alloc_idx0(alloc_idx0), .alloc_idx1(alloc_idx1),
    .free_count(free_count), .empty(empty), .double_free(double_free)
  );

  always #5 clock = ~clock;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: ascending list of free indices plus the double-free flag.
  int fl[$];
  bit mdf;

  typedef struct {
    logic [1:0] req; bit rv; int ridx; bit mp;
    int cnt; logic [1:0] av; int i0; int i1; bit df;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic bit in_list(int v);
    foreach (fl[k]) if (fl[k] == v) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void ins(int v);
    int p = 0;
    while (p < fl.size() && fl[p] < v) p++;
    fl.insert(p, v);
  endfunction

  function automatic void model_reset();
    fl.delete();
    for (int i = 1; i < PRF_SIZE; i++) fl.push_back(i);
    mdf = 1'b0;
  endfunction

  function automatic void model_step();
    bit used[PRF_SIZE];
    int n, take, ridx;
    bit g0, g1, rel, pre;
    if (reset) begin
      model_reset();
      return;
    end
    if (mispredict_sig) begin
      foreach (used[i]) used[i] = 1'b0;
      for (int a = 0; a < ARF_SIZE; a++) used[int'(mispredict_up_idx[a*IDX_W +: IDX_W])] = 1'b1;
      fl.delete();
      for (int i = 1; i < PRF_SIZE; i++) if (!used[i]) fl.push_back(i);
      mdf = 1'b0;
      return;
    end
    n    = fl.size();
    g0   = alloc_req[0] && n >= 1;
    g1   = alloc_req[1] && (alloc_req[0] ? n >= 2 : n >= 1);
    ridx = int'(RRAT_free_idx);
    rel  = RRAT_free_valid && ridx != 0;
    pre  = rel && in_list(ridx);
    take = int'(g0) + int'(g1);
    for (int k = 0; k < take; k++) void'(fl.pop_front());
    if (rel && !pre) ins(ridx);
    mdf = pre;
  endfunction

  function automatic int exp_i0();
    return fl.size() >= 1 ? fl[0] : 0;
  endfunction

  function automatic int exp_i1();
    if (alloc_req[0]) return fl.size() >= 2 ? fl[1] : 0;
    return exp_i0();
  endfunction

  task automatic check_model(string tag);
    int av;
    av = mispredict_sig ? 0 : ((fl.size() >= 2) ? 3 : (fl.size() >= 1) ? 1 : 0);
    chk({tag, ".cnt"},   int'(free_count),  fl.size());
    chk({tag, ".av"},    int'(alloc_valid), av);
    chk({tag, ".i0"},    int'(alloc_idx0),  exp_i0());
    chk({tag, ".i1"},    int'(alloc_idx1),  exp_i1());
    chk({tag, ".empty"}, int'(empty),       int'(fl.size() == 0));
    chk({tag, ".df"},    int'(double_free), int'(mdf));
  endtask

  task automatic drive(logic [1:0] req, bit rv, int ridx, bit mp);
    alloc_req       = req;
    RRAT_free_valid = rv;
    RRAT_free_idx   = IDX_W'(ridx);
    mispredict_sig  = mp;
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic do_step(string tag, logic [1:0] req, bit rv, int ridx, bit mp);
    drive(req, rv, ridx, mp);
    #1 check_model(tag);
    tick();
  endtask

  task automatic set_map(int e0, int e1, int e2, int e3, int e4);
    mispredict_up_idx = '0;
    mispredict_up_idx[0*IDX_W +: IDX_W] = IDX_W'(e0);
    mispredict_up_idx[1*IDX_W +: IDX_W] = IDX_W'(e1);
    mispredict_up_idx[2*IDX_W +: IDX_W] = IDX_W'(e2);
    mispredict_up_idx[3*IDX_W +: IDX_W] = IDX_W'(e3);
    mispredict_up_idx[4*IDX_W +: IDX_W] = IDX_W'(e4);
  endtask

  initial begin
    tbl[0]  = '{2'b11, 0, 0,  0, 63, 2'b11, 1,  2,  0};
    tbl[1]  = '{2'b11, 0, 0,  0, 61, 2'b11, 3,  4,  0};
    tbl[2]  = '{2'b11, 0, 0,  0, 59, 2'b11, 5,  6,  0};
    tbl[3]  = '{2'b11, 0, 0,  0, 57, 2'b11, 7,  8,  0};
    tbl[4]  = '{2'b01, 1, 2,  0, 55, 2'b11, 9,  10, 0};
    tbl[5]  = '{2'b00, 0, 0,  0, 55, 2'b11, 2,  2,  0};
    tbl[6]  = '{2'b11, 0, 0,  1, 55, 2'b00, 2,  10, 0};
    tbl[7]  = '{2'b00, 0, 0,  0, 58, 2'b11, 1,  1,  0};
    tbl[8]  = '{2'b11, 0, 0,  0, 58, 2'b11, 1,  2,  0};
    tbl[9]  = '{2'b11, 0, 0,  0, 56, 2'b11, 4,  7,  0};
    tbl[10] = '{2'b00, 1, 10, 0, 54, 2'b11, 10, 10, 0};
    tbl[11] = '{2'b00, 0, 0,  0, 54, 2'b11, 10, 10, 1};
    tbl[12] = '{2'b00, 0, 0,  0, 54, 2'b11, 10, 10, 0};

    reset = 1'b1;
    drive(2'b00, 0, 0, 0);
    set_map(8, 3, 9, 6, 5);
    @(negedge clock);
    tick();
    tick();
    reset = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].req, tbl[i].rv, tbl[i].ridx, tbl[i].mp);
      #1;
      chk($sformatf("row%0d.cnt", i),   int'(free_count),  tbl[i].cnt);
      chk($sformatf("row%0d.av", i),    int'(alloc_valid), int'(tbl[i].av));
      chk($sformatf("row%0d.i0", i),    int'(alloc_idx0),  tbl[i].i0);
      chk($sformatf("row%0d.i1", i),    int'(alloc_idx1),  tbl[i].i1);
      chk($sformatf("row%0d.empty", i), int'(empty),       int'(tbl[i].cnt == 0));
      chk($sformatf("row%0d.df", i),    int'(double_free), int'(tbl[i].df));
      tick();
    end

    // Drain down to a single free entry, then ask for two.
    while (fl.size() > 1) do_step("drain", (fl.size() >= 3) ? 2'b11 : 2'b01, 0, 0, 0);
    drive(2'b11, 0, 0, 0);
    #1;
    chk("last.av", int'(alloc_valid), 1);
    chk("last.i0", int'(alloc_idx0), 63);
    chk("last.i1", int'(alloc_idx1), 0);
    tick();
    #1;
    chk("empty.flag", int'(empty), 1);
    chk("empty.av", int'(alloc_valid), 0);
    chk("empty.cnt", int'(free_count), 0);
    tick();
    chk("empty_hold.cnt", int'(free_count), 0);
    drive(2'b00, 1, 5, 0);
    tick();
    #1;
    chk("refill.cnt", int'(free_count), 1);
    chk("refill.i0", int'(alloc_idx0), 5);
    drive(2'b11, 0, 0, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(2'b00, 0, 0, 0);
    #1;
    chk("midreset.cnt", int'(free_count), 63);
    chk("midreset.i0", int'(alloc_idx0), 1);

    for (int c = 0; c < 600; c++) begin
      bit mp;
      reset = ($urandom_range(0, 149) == 0);
      mp = ($urandom_range(0, 19) == 0);
      if (mp)
        for (int a = 0; a < ARF_SIZE; a++)
          mispredict_up_idx[a*IDX_W +: IDX_W] =
            ($urandom_range(0, 3) == 0) ? '0 : IDX_W'($urandom_range(1, PRF_SIZE-1));
      do_step($sformatf("rnd%0d", c), 2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
              $urandom_range(0, PRF_SIZE-1), mp);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
